// File: rtl/button_gesture_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_gesture_ctrl_pkg : shared state encoding and event codes          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package button_gesture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS1  = 3'd1,
    ST_HELD    = 3'd2,
    ST_WAIT2   = 3'd3,
    ST_PRESS2  = 3'd4,
    ST_WAITREL = 3'd5
  } state_e;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_SHORT  = 3'd1;
  localparam logic [2:0] EV_DOUBLE = 3'd2;
  localparam logic [2:0] EV_LONG   = 3'd3;
  localparam logic [2:0] EV_REPEAT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/button_event_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_event_reg : single-entry valid/ready event holder, sticky overrun |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_event_reg
  import button_gesture_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [2:0] code_i,
  input  logic       ready_i,
  input  logic       clr_i,
  output logic       valid_o,
  output logic [2:0] code_o,
  output logic       overrun_o
);

  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;
  logic       ovr_q, ovr_d;
  logic       w_accept;
  logic       w_drop;

  // A held event being consumed frees the slot in the same cycle.
  assign w_accept = push_i && (!valid_q || ready_i);
  assign w_drop   = push_i && valid_q && !ready_i;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      code_d  = EV_NONE;
    end
    if (w_accept) begin
      valid_d = 1'b1;
      code_d  = code_i;
    end
    if (w_drop) begin
      ovr_d = 1'b1;
    end else if (clr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= EV_NONE;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o   = valid_q;
  assign code_o    = code_q;
  assign overrun_o = ovr_q;

endmodule
`default_nettype wire

// File: rtl/button_gesture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_gesture_ctrl : turns debounced edges into click/double/long/repeat|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_gesture_ctrl
  import button_gesture_ctrl_pkg::*;
#(
  parameter int LONG_TICKS   = 1000,
  parameter int DOUBLE_TICKS = 300,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       btn_rise,
  input  logic       btn_fall,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  input  logic       ev_ready,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] C_DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
  localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_rise, w_fall, w_step;
  logic             w_long_hit, w_dbl_hit, w_rep_hit;
  logic             w_push;
  logic [2:0]       w_push_code;

  // Simultaneous rise+fall cancels out, yet still blocks the tick from counting.
  assign w_rise = btn_rise & ~btn_fall;
  assign w_fall = btn_fall & ~btn_rise;
  assign w_step = tick & ~btn_rise & ~btn_fall;

  assign w_long_hit = w_step && (cnt_q == C_LONG_LAST);
  assign w_dbl_hit  = w_step && (cnt_q == C_DOUBLE_LAST);
  assign w_rep_hit  = w_step && (cnt_q == C_REPEAT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = w_step ? cnt_q + 1'b1 : cnt_q;
    w_push      = 1'b0;
    w_push_code = EV_NONE;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_fall) begin
          state_d = ST_WAIT2;
        end else if (w_long_hit) begin
          w_push      = 1'b1;
          w_push_code = EV_LONG;
          state_d     = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          state_d = ST_IDLE;
        end else if (w_rep_hit) begin
          w_push      = 1'b1;
          w_push_code = EV_REPEAT;
          cnt_d       = '0;
        end
      end
      ST_WAIT2: begin
        if (w_rise) begin
          state_d = ST_PRESS2;
        end else if (w_dbl_hit) begin
          w_push      = 1'b1;
          w_push_code = EV_SHORT;
          state_d     = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (w_fall) begin
          w_push      = 1'b1;
          w_push_code = EV_DOUBLE;
          state_d     = ST_IDLE;
        end else if (w_long_hit) begin
          w_push      = 1'b1;
          w_push_code = EV_DOUBLE;
          state_d     = ST_WAITREL;
        end
      end
      ST_WAITREL: begin
        cnt_d = '0;
        if (w_fall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      w_push      = 1'b0;
      w_push_code = EV_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  button_event_reg u_event_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (w_push),
    .code_i    (w_push_code),
    .ready_i   (ev_ready),
    .clr_i     (ovr_clr),
    .valid_o   (ev_valid),
    .code_o    (ev_code),
    .overrun_o (overrun)
  );

endmodule
`default_nettype wire

// File: tb/tb_button_gesture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_gesture_ctrl : scoreboard bench for button_gesture_ctrl        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_button_gesture_ctrl;

  localparam int L = 10;
  localparam int D = 5;
  localparam int R = 3;
  localparam int NG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic       btn_rise = 1'b0;
  logic       btn_fall = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       ev_valid, overrun, busy;
  logic [2:0] ev_code;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  bit rand_mode = 1'b0;

  button_gesture_ctrl #(
    .LONG_TICKS   (L),
    .DOUBLE_TICKS (D),
    .REPEAT_TICKS (R),
    .CNT_W        (12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .tick     (tick),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One tick every 4 clk cycles.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Random consumer: never stalls an event long enough to lose the next one.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        hold = ev_valid ? hold + 1 : 0;
        ev_ready = (hold >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every accepted event must be the next expected one.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got code %0d, expected none (t=%0t)", ev_code, $time);
        end else begin
          e = exp_q.pop_front();
          chk("event_code", 32'(ev_code), 32'(e));
        end
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    #1;
  endtask

  task automatic rise();
    btn_rise = 1'b1;
    @(posedge clk);
    #1 btn_rise = 1'b0;
  endtask

  task automatic fall();
    btn_fall = 1'b1;
    @(posedge clk);
    #1 btn_fall = 1'b0;
  endtask

  initial begin
    int H[NG];
    int G[NG];
    int gi;

    en = 1'b1;
    ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cycles(2);

    // Short click
    wait_ticks(1);
    exp_q.push_back(1);
    rise();
    chk("short_busy", 32'(busy), 1);
    wait_ticks(3);
    fall();
    wait_ticks(4);
    chk("short_early", 32'(ev_valid), 0);
    wait_ticks(1);
    chk("short_valid", 32'(ev_valid), 1);
    chk("short_code", 32'(ev_code), 1);
    chk("short_idle", 32'(busy), 0);
    cycles(1);
    chk("short_consumed", 32'(ev_valid), 0);

    // Double click
    wait_ticks(1);
    exp_q.push_back(2);
    rise();
    wait_ticks(2);
    fall();
    wait_ticks(3);
    rise();
    wait_ticks(2);
    fall();
    chk("double_code", 32'(ev_code), 2);
    wait_ticks(7);
    chk("double_idle", 32'(busy), 0);

    // Long press with repeats
    wait_ticks(1);
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(4);
    exp_q.push_back(4);
    rise();
    wait_ticks(9);
    chk("long_early", 32'(ev_valid), 0);
    wait_ticks(1);
    chk("long_code", 32'(ev_code), 3);
    for (int k = 0; k < 3; k++) begin
      wait_ticks(3);
      chk("repeat_code", 32'(ev_code), 4);
    end
    fall();
    wait_ticks(4);
    chk("long_idle", 32'(busy), 0);

    // Both edges at once in IDLE
    btn_rise = 1'b1;
    btn_fall = 1'b1;
    @(posedge clk);
    #1;
    btn_rise = 1'b0;
    btn_fall = 1'b0;
    chk("both_edges_idle", 32'(busy), 0);

    // Edge coincident with tick in PRESS1 does not advance the count
    wait_ticks(1);
    exp_q.push_back(3);
    rise();
    wait_ticks(2);
    cycles(3);
    btn_rise = 1'b1;
    @(posedge clk);
    #1 btn_rise = 1'b0;
    wait_ticks(7);
    chk("coincident_delay", 32'(ev_valid), 0);
    wait_ticks(1);
    chk("coincident_long", 32'(ev_code), 3);
    fall();
    wait_ticks(2);

    // Backpressure: SHORT held, DOUBLE dropped
    ev_ready = 1'b0;
    wait_ticks(1);
    rise();
    fall();
    wait_ticks(5);
    chk("bp_short", 32'(ev_code), 1);
    rise();
    fall();
    wait_ticks(1);
    rise();
    fall();
    cycles(1);
    chk("bp_held", 32'(ev_code), 1);
    chk("bp_overrun", 32'(overrun), 1);
    exp_q.push_back(1);
    ev_ready = 1'b1;
    @(posedge clk);
    #1 ev_ready = 1'b0;
    chk("bp_drain", 32'(ev_valid), 0);
    chk("bp_code0", 32'(ev_code), 0);
    chk("bp_overrun_kept", 32'(overrun), 1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);

    // Disable in PRESS2 with an event pending
    wait_ticks(1);
    rise();
    fall();
    wait_ticks(5);
    rise();
    fall();
    wait_ticks(1);
    rise();
    en = 1'b0;
    cycles(1);
    chk("en_busy", 32'(busy), 0);
    fall();
    wait_ticks(6);
    chk("en_pending", 32'(ev_code), 1);
    chk("en_no_double", 32'(overrun), 0);
    en = 1'b1;
    exp_q.push_back(1);
    ev_ready = 1'b1;
    cycles(1);
    chk("en_drain", 32'(ev_valid), 0);

    // Async reset while HELD
    wait_ticks(1);
    exp_q.push_back(3);
    rise();
    wait_ticks(11);
    chk("rst_held_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ev_valid), 0);
    chk("arst_code", 32'(ev_code), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_overrun", 32'(overrun), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(5);
    chk("post_rst_idle", 32'(busy), 0);

    // Random gestures against a gesture-level model
    for (int i = 0; i < NG; i++) begin
      H[i] = $urandom_range(0, 16);
      G[i] = $urandom_range(1, 7);
    end
    G[NG-1] = D + 2;
    gi = 0;
    while (gi < NG) begin
      if (H[gi] >= L) begin
        exp_q.push_back(3);
        for (int k = 0; k < (H[gi] - L) / R; k++) exp_q.push_back(4);
        gi++;
      end else if (G[gi] >= D) begin
        exp_q.push_back(1);
        gi++;
      end else begin
        exp_q.push_back(2);
        gi += 2;
      end
    end
    rand_mode = 1'b1;
    wait_ticks(1);
    for (int i = 0; i < NG; i++) begin
      rise();
      wait_ticks(H[i]);
      fall();
      wait_ticks(G[i]);
    end
    rand_mode = 1'b0;
    #2 ev_ready = 1'b1;
    cycles(20);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("rand_overrun", 32'(overrun), 0);
    chk("rand_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
